// File: rtl/led_seq_pkg.sv
// Shared types and pattern constants for the LED sequencer.
// Seeds and wrap targets are returned 32 bits wide; callers truncate to BITS.
package led_seq_pkg;

    typedef enum logic [1:0] {
        BOUNCE = 2'd0,
        ROT_L  = 2'd1,
        ROT_R  = 2'd2,
        FILL   = 2'd3
    } mode_t;

    localparam int unsigned MAX_BITS = 32;

    // Pattern loaded into q when a mode is (re)entered.
    function automatic logic [MAX_BITS-1:0] seed_pattern(mode_t m, int unsigned bits);
        logic [MAX_BITS-1:0] r;
        r = '0;
        case (m)
            BOUNCE:  r = 32'd1;
            ROT_L:   r = 32'd1;
            ROT_R:   r = 32'd1 << (bits - 1);
            default: r = '0;
        endcase
        return r;
    endfunction

    // Value of q that marks the first state of a new pattern period.
    function automatic logic [MAX_BITS-1:0] wrap_pattern(mode_t m, int unsigned bits);
        logic [MAX_BITS-1:0] r;
        r = '0;
        case (m)
            BOUNCE:  r = 32'd1;
            ROT_L:   r = 32'd1;
            ROT_R:   r = 32'd1 << (bits - 1);
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/led_sequencer_tick_gen.sv
// Programmable prescaler: tick is high on the enabled edge where count == div,
// and count restarts from zero on that same edge.
module tick_gen #(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] count;

    assign tick = en && (count == div);

    // A count above a freshly lowered div simply runs through the full range.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            if (tick) begin
                count <= '0;
            end else begin
                count <= count + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// LED pattern generator: bounce, rotate-left, rotate-right and bar-fill,
// stepped by a prescaler, with run/pause and a period-complete pulse.
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int BITS  = 10,
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] div,
    output logic [BITS-1:0]  q,
    output logic             dir,
    output logic             wrap
);

    mode_t           mode_q;
    mode_t           mode_in;
    logic            mode_chg;
    logic            tick;
    logic [BITS-1:0] step_q;
    logic            step_dir;
    logic [BITS-1:0] seed_q;
    logic [BITS-1:0] wrap_q;
    logic            step_wraps;

    assign mode_in  = mode_t'(mode);
    assign mode_chg = (mode_in != mode_q);

    tick_gen #(
        .DIV_W(DIV_W)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .clr (mode_chg),
        .div (div),
        .tick(tick)
    );

    assign seed_q = BITS'(seed_pattern(mode_in, BITS));
    assign wrap_q = BITS'(wrap_pattern(mode_q, BITS));

    // Next pattern if a step is taken under the stored mode.
    always_comb begin
        step_q   = q;
        step_dir = dir;
        case (mode_q)
            BOUNCE: begin
                if (dir && q[BITS-1]) begin
                    step_dir = 1'b0;
                    step_q   = q >> 1;
                end else if (!dir && q[0]) begin
                    step_dir = 1'b1;
                    step_q   = q << 1;
                end else if (dir) begin
                    step_q = q << 1;
                end else begin
                    step_q = q >> 1;
                end
            end
            ROT_L:   step_q = {q[BITS-2:0], q[BITS-1]};
            ROT_R:   step_q = {q[0], q[BITS-1:1]};
            default: step_q = (&q) ? '0 : {q[BITS-2:0], 1'b1};
        endcase
    end

    assign step_wraps = (step_q == wrap_q);

    // A mode change outranks a step and is taken whether or not en is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q      <= BITS'(1);
            dir    <= 1'b1;
            wrap   <= 1'b0;
            mode_q <= BOUNCE;
        end else if (mode_chg) begin
            q      <= seed_q;
            wrap   <= 1'b0;
            mode_q <= mode_in;
            if (mode_in == BOUNCE) begin
                dir <= 1'b1;
            end
        end else if (tick) begin
            q    <= step_q;
            dir  <= step_dir;
            wrap <= step_wraps;
        end else begin
            wrap <= 1'b0;
        end
    end

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer: index-based pattern model checked every cycle,
// plus directed literal sequences drained from an expected queue.
module tb_led_sequencer;

    localparam int B  = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en  = 1'b1;
    logic [1:0]    mode = 2'd0;
    logic [DW-1:0] div = '0;
    logic [B-1:0]  q;
    logic          dir;
    logic          wrap;

    int n_checks = 0;
    int n_fail   = 0;

    logic [B-1:0] exp_q[$];
    logic         exp_w[$];

    led_sequencer #(
        .BITS (B),
        .DIV_W(DW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .mode(mode),
        .div (div),
        .q   (q),
        .dir (dir),
        .wrap(wrap)
    );

    always #5 clk = ~clk;

    // ---------------- model: pattern as an index into its period ----------------
    logic [1:0] m_mode = 2'd0;
    int         m_k    = 0;
    int         m_cnt  = 0;
    logic       m_dir  = 1'b1;
    logic       m_wrap = 1'b0;

    function automatic int period(logic [1:0] md);
        case (md)
            2'd0:    return 2 * (B - 1);
            2'd1:    return B;
            2'd2:    return B;
            default: return B + 1;
        endcase
    endfunction

    function automatic logic [B-1:0] pat(logic [1:0] md, int k);
        int p;
        case (md)
            2'd0: begin
                p = (k <= B - 1) ? k : 2 * (B - 1) - k;
                return B'(1) << p;
            end
            2'd1:    return B'(1) << k;
            2'd2:    return B'(1) << (B - 1 - k);
            default: return B'((1 << k) - 1);
        endcase
    endfunction

    function automatic int nk(logic [1:0] md, int k);
        return (k + 1) % period(md);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode <= 2'd0;
            m_k    <= 0;
            m_cnt  <= 0;
            m_dir  <= 1'b1;
            m_wrap <= 1'b0;
        end else if (mode != m_mode) begin
            m_mode <= mode;
            m_k    <= 0;
            m_cnt  <= 0;
            m_wrap <= 1'b0;
            if (mode == 2'd0) m_dir <= 1'b1;
        end else if (en && m_cnt == int'(div)) begin
            m_cnt  <= 0;
            m_k    <= nk(m_mode, m_k);
            m_wrap <= (nk(m_mode, m_k) == 0);
            // Bounce climbs for indices 1..B-1 and falls for the rest of the period.
            if (m_mode == 2'd0)
                m_dir <= (nk(m_mode, m_k) >= 1) && (nk(m_mode, m_k) <= B - 1);
        end else begin
            if (en) m_cnt <= (m_cnt + 1) % (1 << DW);
            m_wrap <= 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- every-cycle comparison against the model ----------------
    always @(negedge clk) begin
        check("model_q", 32'(q), 32'(pat(m_mode, m_k)));
        check("model_dir", 32'(dir), 32'(m_dir));
        check("model_wrap", 32'(wrap), 32'(m_wrap));
    end

    // ---------------- driver helpers ----------------
    task automatic drive_slot();
        @(posedge clk);
        #2;
    endtask

    task automatic drain_exp(input string name, input int n);
        logic [B-1:0] eq;
        logic         ew;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            eq = exp_q.pop_front();
            ew = exp_w.pop_front();
            check({name, "_q"}, 32'(q), 32'(eq));
            check({name, "_wrap"}, 32'(wrap), 32'(ew));
        end
    endtask

    logic [B-1:0] t1_q[8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    logic         t1_w[8] = '{0, 0, 0, 0, 0, 0, 1, 0};
    logic         t1_d[8] = '{1, 1, 1, 1, 0, 0, 0, 1};
    logic [B-1:0] t3_q[6] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b0000};
    logic         t3_w[6] = '{0, 0, 0, 0, 0, 1};

    // ---------------- stimulus ----------------
    initial begin
        logic [B-1:0] held_q;
        logic         held_d;
        int           guard;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_q", 32'(q), 32'd1);
        check("reset_dir", 32'(dir), 32'd1);
        check("reset_wrap", 32'(wrap), 32'd0);

        // Bounce at full speed straight out of reset.
        drive_slot();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("bounce_q", 32'(q), 32'(t1_q[i]));
            check("bounce_dir", 32'(dir), 32'(t1_d[i]));
            check("bounce_wrap", 32'(wrap), 32'(t1_w[i]));
        end

        // Rotate left, one step every four cycles.
        drive_slot();
        mode = 2'd1;
        div  = 8'd3;
        @(posedge clk);
        for (int j = 0; j < 17; j++) begin
            exp_q.push_back(B'(1) << ((j / 4) % B));
            exp_w.push_back(j == 16);
        end
        drain_exp("rotl", 17);

        // Bar fill at full speed.
        drive_slot();
        mode = 2'd3;
        div  = 8'd0;
        @(posedge clk);
        for (int j = 0; j < 6; j++) begin
            exp_q.push_back(t3_q[j]);
            exp_w.push_back(t3_w[j]);
        end
        drain_exp("fill", 6);

        // Rotate right with a 10-cycle pause in the middle.
        drive_slot();
        mode = 2'd2;
        div  = 8'd5;
        repeat (8) drive_slot();
        en = 1'b0;
        @(negedge clk);
        held_q = q;
        held_d = dir;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("pause_q", 32'(q), 32'(held_q));
            check("pause_dir", 32'(dir), 32'(held_d));
            check("pause_wrap", 32'(wrap), 32'd0);
        end
        drive_slot();
        en = 1'b1;
        repeat (20) drive_slot();

        // Bounce -> rotate right on an edge that would also have stepped.
        mode = 2'd0;
        div  = 8'd2;
        @(posedge clk);
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (m_cnt != 2 && guard < 10);
        check("step_edge_wait", 32'(guard < 10), 32'd1);
        #1;
        mode = 2'd2;
        exp_q.push_back(4'b1000); exp_w.push_back(1'b0);
        exp_q.push_back(4'b1000); exp_w.push_back(1'b0);
        exp_q.push_back(4'b1000); exp_w.push_back(1'b0);
        exp_q.push_back(4'b0100); exp_w.push_back(1'b0);
        drain_exp("chg_on_step", 4);

        // Asynchronous reset between edges during fill.
        drive_slot();
        mode = 2'd3;
        div  = 8'd0;
        @(posedge clk);
        for (int j = 0; j < 4; j++) begin
            exp_q.push_back(t3_q[j]);
            exp_w.push_back(t3_w[j]);
        end
        drain_exp("fill_pre_rst", 4);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_q", 32'(q), 32'd1);
        check("async_rst_dir", 32'(dir), 32'd1);
        check("async_rst_wrap", 32'(wrap), 32'd0);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_reload_q", 32'(q), 32'd0);

        // Randomised run: mode, enable, period and occasional reset pulses.
        for (int c = 0; c < 1500; c++) begin
            int r;
            drive_slot();
            r = $urandom_range(0, 199);
            if (r < 6) mode = 2'($urandom_range(0, 3));
            if (r >= 6 && r < 16) div = DW'($urandom_range(0, 3));
            en = ($urandom_range(0, 7) != 0);
            if (r == 199) begin
                #1;
                rst = 1'b1;
                #1;
                rst = 1'b0;
            end
        end

        drive_slot();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/led_sequencer.md
# led_sequencer

Parametrised LED pattern generator driving a board LED bank. A programmable prescaler steps one of four patterns: bounce, rotate-left, rotate-right, bar-fill. It adds run/pause control and a period-complete pulse. It sits between the top-level switch/button inputs and the LED pins, replacing the fixed-width bouncing shifter.

## Interface
- BITS, 10, number of LEDs; legal range 2..32
- DIV_W, 24, prescaler width

- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  run enable; 0 freezes prescaler and pattern
- mode  in  2  pattern select: 0 BOUNCE, 1 ROT_L, 2 ROT_R, 3 FILL
- div  in  DIV_W  step period minus one; one step every div+1 enabled cycles
- q  out  BITS  LED pattern, registered
- dir  out  1  bounce direction, registered; 1 = toward MSB
- wrap  out  1  one-cycle pulse, registered: step just completed a pattern period

## Operation
- Reset values:
  - q = 1 (LSB lit), dir = 1, wrap = 0
  - prescaler count = 0
  - stored mode = BOUNCE
- Prescaler:
  - With en = 1, count increments each cycle.
  - When count == div, count clears to 0 and a step occurs on that same edge.
  - div = 0 gives a step every enabled cycle.
  - If div is lowered below the current count, the counter wraps through its full range; not an error.
- Step rules:
  - BOUNCE:
    - if dir and q[BITS-1]: dir <= 0, q <= q >> 1
    - else if !dir and q[0]: dir <= 1, q <= q << 1
    - else shift one place in direction dir
  - ROT_L: q <= {q[BITS-2:0], q[BITS-1]}
  - ROT_R: q <= {q[0], q[BITS-1:1]}
  - FILL: if q all ones, q <= 0; else q <= {q[BITS-2:0], 1'b1}
  - dir is held in all modes except BOUNCE.
- wrap is set high for exactly the cycle after the step edge (concurrent with the new q) when the new q equals:
  - BOUNCE: 1 (reached LSB moving down)
  - ROT_L: 1
  - ROT_R: 1 << (BITS-1)
  - FILL: 0
  - In all other cycles wrap = 0.
- Mode change:
  - When the mode input differs from the stored mode at a clock edge, the block reloads the seed, clears the count, forces wrap = 0 and stores the new mode.
  - This happens independently of en.
  - Seeds:
    - BOUNCE: q = 1, dir = 1
    - ROT_L: q = 1
    - ROT_R: q = 1 << (BITS-1)
    - FILL: q = 0
  - A mode change takes priority over a step on the same edge.
- en = 0: count, q and dir hold; wrap = 0.
- rst asserted mid-operation returns every register to its reset value immediately, independent of clk.

## Timing
- Step latency: q changes on the (div+1)th enabled rising edge after reset, mode reload or a prior step.
- Pattern periods, in steps:
  - BOUNCE: 2·(BITS-1)
  - ROT_L / ROT_R: BITS
  - FILL: BITS+1
- Mode reload: seed is visible on q one cycle after the edge where the new mode is first sampled.
- All outputs come directly from flops; no combinational input-to-output path.

## Structure
- Package led_seq_pkg holds:
  - the mode_t enum (BOUNCE, ROT_L, ROT_R, FILL)
  - the seed constants as a function of BITS
- Sub-module tick_gen holds the prescaler: parameter DIV_W; ports clk, rst, en, clr, div, tick.
- The pattern register, dir, stored mode and wrap live in led_sequencer.

## Test plan
- Reset, BITS=4, div=0, en=1, mode=BOUNCE -> q sequence 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010. dir falls to 0 on the step that produces 0100 after 1000. wrap pulses together with the 0001.
- div=3, ROT_L, BITS=4 -> q changes every 4 cycles: 0001, 0010, 0100, 1000, 0001. wrap is high only with the final 0001.
- FILL, div=0, BITS=4 -> 0000, 0001, 0011, 0111, 1111, 0000. wrap is high with the 0000.
- en dropped for 10 cycles mid-ROT_R -> q, count and dir frozen, wrap = 0. After resume, the next step lands at the remaining count, not restarted.
- mode switched BOUNCE to ROT_R on a step edge -> q = 1000 next cycle, count cleared, no step applied, wrap = 0.
- rst pulsed asynchronously between clock edges during FILL with q = 0111 -> q = 0001, dir = 1, wrap = 0 immediately. Behaviour is BOUNCE until the mode input is re-sampled.
